serial_addsub: RTL

SERIAL_ADDSUB -- requirements
Module: serial_addsub

---
 rtl/serial_addsub.sv | 114 +++++++++++
 1 files changed

// File: rtl/serial_addsub.sv
// serial_addsub
//   Digit-serial adder/subtractor. Operands arrive LSB-first, DIGIT bits per
//   accepted beat, and a WORD-bit result leaves at the same rate with one
//   cycle of latency. Subtraction is done as A + ~B + 1, with the +1 supplied
//   by preloading the carry register with the mode bit.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   start      begins an operation when sampled high while idle
//   sub        mode captured with start: 0 = A+B, 1 = A-B
//   in_valid   a_d/b_d hold a valid digit this cycle
//   a_d, b_d   operand digits, LSB-first across beats
//   busy       high while an operation is in progress
//   f_d        registered result digit (held when out_valid is low)
//   out_valid  one-cycle pulse per accepted digit
//   done       one-cycle pulse together with the last out_valid of a word
//   cout       final carry of the word (for subtraction, 1 = no borrow)
//   ovf        two's-complement overflow of the word
module serial_addsub #(
  parameter int DIGIT = 1,
  parameter int WORD  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic             in_valid,
  input  logic [DIGIT-1:0] a_d,
  input  logic [DIGIT-1:0] b_d,
  output logic             busy,
  output logic [DIGIT-1:0] f_d,
  output logic             out_valid,
  output logic             done,
  output logic             cout,
  output logic             ovf
);

  localparam int BEATS = WORD / DIGIT;
  // A one-beat word still gets a 1-bit counter so the declaration stays legal.
  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  localparam logic IDLE = 1'b0;
  localparam logic RUN  = 1'b1;

  logic          state;
  logic          sub_mode;
  logic          carry;
  logic [CW-1:0] beat_cnt;

  logic [DIGIT-1:0] b_eff;
  logic [DIGIT:0]   sum;
  logic             msb_cin;

  // One digit slice of the adder. The carry into the digit's top bit is
  // recovered from that bit's inputs and output, which avoids a separate
  // narrower adder just to expose it for the overflow flag.
  always_comb begin
    b_eff   = sub_mode ? ~b_d : b_d;
    sum     = {1'b0, a_d} + {1'b0, b_eff} + {{DIGIT{1'b0}}, carry};
    msb_cin = a_d[DIGIT-1] ^ b_eff[DIGIT-1] ^ sum[DIGIT-1];
  end

  assign busy = (state == RUN);

  // Control and datapath registers. out_valid and done default low every
  // cycle so they are single-cycle pulses; f_d, cout and ovf keep their
  // values until something explicitly updates them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      sub_mode  <= 1'b0;
      carry     <= 1'b0;
      beat_cnt  <= '0;
      f_d       <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      done      <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          state    <= RUN;
          sub_mode <= sub;
          carry    <= sub;
          beat_cnt <= '0;
          cout     <= 1'b0;
          ovf      <= 1'b0;
        end
      end else begin
        // start is deliberately not looked at here: a running word cannot
        // be restarted.
        if (in_valid) begin
          f_d       <= sum[DIGIT-1:0];
          carry     <= sum[DIGIT];
          out_valid <= 1'b1;
          if (beat_cnt == LAST_BEAT) begin
            done     <= 1'b1;
            cout     <= sum[DIGIT];
            ovf      <= msb_cin ^ sum[DIGIT];
            beat_cnt <= '0;
            state    <= IDLE;
          end else begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule
